lfsr_cipher_engine: RTL and testbench
=====================================

# lfsr_cipher_engine

Parametrised LFSR stream-cipher engine that drives the existing `dat_mem` data memory directly. It reads its configuration words (preamble length, taps, seed) from memory and writes an encrypted stream: a pad-character preamble followed by the message. A decrypt mode reverses the operation. Operation is started by a one-cycle handshake and ends with a `done` pulse, so a top-level or testbench can run it repeatedly without re-initialising.

## Interface
- `DW`, 8: memory data width; must satisfy `LW` <= `DW`.
- `AW`, 8: memory address width; all address arithmetic is modulo 2^`AW`.
- `LW`, 6: LFSR width.
- `MSG_LEN`, 50: message length in words.
- `MAX_PRE`, 15: upper clamp on preamble length.
- `CFG_BASE`, 61: address of pre_len; taps at +1, seed at +2.
- `SRC_BASE`, 0: plaintext source (encrypt).
- `DST_BASE`, 64: ciphertext region.
- `PT_BASE`, 128: recovered-plaintext destination (decrypt).
- `PAD`, 8'h5F: preamble character (ASCII `_`).
- `clk` input 1: the only clock; all state changes on its rising edge.
- `init` input 1: reset, asynchronous and active-high.
- `start` input 1: request; sampled only in IDLE.
- `mode` input 1: 0 = encrypt, 1 = decrypt; sampled with `start`.
- `raddr` output `AW`: memory read address.
- `data_out` input `DW`: memory read data, combinational from `raddr` in the same cycle.
- `write_en` output 1: memory write enable.
- `waddr` output `AW`: memory write address.
- `data_in` output `DW`: memory write data.
- `busy` output 1: high from the cycle after start is accepted until DONE.
- `done` output 1: one-cycle pulse in DONE.
- `err` output 1: set in DONE if taps==0 or seed==0; held until the next accepted start.

## Operation
- LFSR step: `lfsr <= {lfsr[LW-2:0], ^(lfsr & taps)}`.
- Key word: `K` = zero-extended `lfsr` to `DW` bits.
- States: IDLE, CFG_PRE, CFG_TAPS, CFG_SEED, PRE, MSG, DONE.
- IDLE -> CFG_PRE on `start`=1. `mode` is latched in that same cycle.
- CFG_PRE: `raddr`=CFG_BASE. Latch `p` = min(`data_out`, MAX_PRE).
- CFG_TAPS: `raddr`=CFG_BASE+1. Latch taps = `data_out[LW-1:0]`.
- CFG_SEED: `raddr`=CFG_BASE+2. Load `lfsr` = `data_out[LW-1:0]`.
- CFG_SEED exits as follows:
  - If taps==0 or seed==0, go to DONE with `err`=1 and perform no writes.
  - Else if `p`==0, go to MSG.
  - Else go to PRE.
- PRE, index i = 0..p-1:
  - Encrypt: `write_en`=1, `waddr`=DST_BASE+i, `data_in`=PAD^K.
  - Decrypt: `write_en`=0 (the LFSR only skips ahead).
  - The LFSR steps every PRE cycle.
- MSG, index j = 0..MSG_LEN-1, with `write_en`=1 and the LFSR stepping every cycle:
  - Encrypt: `raddr`=SRC_BASE+j, `waddr`=DST_BASE+p+j, `data_in`=`data_out`^K.
  - Decrypt: `raddr`=DST_BASE+p+j, `waddr`=PT_BASE+j, `data_in`=`data_out`^K.
- DONE: `done`=1 for one cycle, then return to IDLE. `start` is ignored in every non-IDLE state.
- In IDLE, CFG_* and DONE, the outputs `write_en`, `raddr`, `waddr` and `data_in` are 0 except for the CFG `raddr` values given above.

## Timing
- Start accepted at edge 0. `busy`=1 from cycle 1.
- Configuration occupies cycles 1-3. PRE occupies cycles 4..3+p.
- Encrypt writes p+MSG_LEN words on consecutive cycles with no bubbles.
- `done` is high in cycle 4+p+MSG_LEN. `busy` is low in that cycle.
- Error path: `done` and `err` are high in cycle 4.
- Reset values while `init`=1: state=IDLE; `busy`, `done`, `err`, `write_en`, `raddr`, `waddr` and `data_in` all 0; `lfsr` 0; latched config 0.
- `init` asserted mid-operation aborts immediately with no further writes. Words already written stay in memory.
- `start` in the DONE cycle is ignored. `start` in the following IDLE cycle is accepted.
- Index counters are wide enough for MAX_PRE+MSG_LEN. Address sums wrap modulo 2^`AW`.

## Test plan
- Encrypt, pre_len=7, taps=6'h21, seed=6'h01, msg "Mr. Watson..." at 0..49:
  - Requires 57 writes at 64..120 matching the testbench reference model.
  - Requires `done` in cycle 61.
- Decrypt of the region written by test 1 (same config):
  - Requires `mem[128..177]` == `mem[0..49]`, no writes during PRE, and `done` in cycle 61.
- pre_len=0, then pre_len=200:
  - pre_len=0 requires the first write at 64 in cycle 4 (MSG directly).
  - pre_len=200 requires clamping to 15 preamble writes at 64..78.
- taps=0 (separately seed=0):
  - Requires `done` and `err` in cycle 4, zero writes, and `err` to clear on the next start.
- `init` pulsed during the MSG phase at j=10:
  - Requires outputs 0 asynchronously, no further writes, and a clean rerun after re-start.
- `start` held high through a run:
  - Requires the second run to begin only in the IDLE cycle after DONE, with `busy`/`done` framing correct for back-to-back runs.

Source files
------------

// File: rtl/lfsr_cipher_engine.sv
// LFSR stream-cipher engine driving a data memory. It reads pre_len/taps/seed from memory,
// then writes a keyed pad preamble plus the message (encrypt) or recovers the plaintext (decrypt).
module lfsr_cipher_engine #(
   parameter int DW = 8,
   parameter int AW = 8,
   parameter int LW = 6,
   parameter int MSG_LEN = 50,
   parameter int MAX_PRE = 15,
   parameter int CFG_BASE = 61,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 64,
   parameter int PT_BASE = 128,
   parameter logic [DW-1:0] PAD = 8'h5F
) (
   input  logic          clk,
   input  logic          init,
   input  logic          start,
   input  logic          mode,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] data_out,
   output logic          write_en,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] data_in,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int CW = $clog2(MAX_PRE + MSG_LEN + 1);
   localparam logic [AW-1:0] A_CFG = AW'(CFG_BASE);
   localparam logic [AW-1:0] A_SRC = AW'(SRC_BASE);
   localparam logic [AW-1:0] A_DST = AW'(DST_BASE);
   localparam logic [AW-1:0] A_PT  = AW'(PT_BASE);
   localparam logic [AW-1:0] A_ONE = AW'(1);
   localparam logic [AW-1:0] A_TWO = AW'(2);
   localparam logic [CW-1:0] C_ONE = CW'(1);
   localparam logic [CW-1:0] C_MAXP = CW'(MAX_PRE);
   localparam logic [CW-1:0] C_MSG_LAST = CW'(MSG_LEN - 1);
   localparam logic [DW-1:0] D_MAXP = DW'(MAX_PRE);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG_PRE, S_CFG_TAPS, S_CFG_SEED, S_PRE, S_MSG, S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;
   logic          r_mode;
   logic          r_err;
   logic [CW-1:0] r_p;
   logic [CW-1:0] r_idx;
   logic [LW-1:0] r_taps;
   logic [LW-1:0] r_lfsr;

   logic [DW-1:0] w_key;
   logic [LW-1:0] w_seed;
   logic [LW-1:0] w_lfsr_next;
   logic [CW-1:0] w_p_clamp;
   logic          w_cfg_bad;
   logic          w_pre_last;
   logic          w_msg_last;

   assign w_key       = DW'(r_lfsr);
   assign w_seed      = data_out[LW-1:0];
   assign w_lfsr_next = {r_lfsr[LW-2:0], ^(r_lfsr & r_taps)};
   assign w_p_clamp   = (data_out > D_MAXP) ? C_MAXP : CW'(data_out);
   assign w_cfg_bad   = (r_taps == {LW{1'b0}}) || (w_seed == {LW{1'b0}});
   assign w_pre_last  = (r_idx == (r_p - C_ONE));
   assign w_msg_last  = (r_idx == C_MSG_LAST);

   assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done = (r_state == S_DONE);
   assign err  = r_err;

   // State register.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and memory-port decode; outputs are idle unless a state drives them.
   always_comb begin
      w_next   = r_state;
      raddr    = {AW{1'b0}};
      waddr    = {AW{1'b0}};
      data_in  = {DW{1'b0}};
      write_en = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_CFG_PRE;
            else       w_next = S_IDLE;
         end
         S_CFG_PRE: begin
            raddr  = A_CFG;
            w_next = S_CFG_TAPS;
         end
         S_CFG_TAPS: begin
            raddr  = A_CFG + A_ONE;
            w_next = S_CFG_SEED;
         end
         S_CFG_SEED: begin
            raddr = A_CFG + A_TWO;
            if (w_cfg_bad)                  w_next = S_DONE;
            else if (r_p == {CW{1'b0}})     w_next = S_MSG;
            else                            w_next = S_PRE;
         end
         S_PRE: begin
            // Decrypt only advances the keystream past the preamble.
            if (!r_mode) begin
               write_en = 1'b1;
               waddr    = A_DST + AW'(r_idx);
               data_in  = PAD ^ w_key;
            end else begin
               write_en = 1'b0;
            end
            if (w_pre_last) w_next = S_MSG;
            else            w_next = S_PRE;
         end
         S_MSG: begin
            write_en = 1'b1;
            data_in  = data_out ^ w_key;
            if (!r_mode) begin
               raddr = A_SRC + AW'(r_idx);
               waddr = A_DST + AW'(r_p) + AW'(r_idx);
            end else begin
               raddr = A_DST + AW'(r_p) + AW'(r_idx);
               waddr = A_PT + AW'(r_idx);
            end
            if (w_msg_last) w_next = S_DONE;
            else            w_next = S_MSG;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Configuration latches, keystream register and phase index.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         r_mode <= 1'b0;
         r_err  <= 1'b0;
         r_p    <= {CW{1'b0}};
         r_idx  <= {CW{1'b0}};
         r_taps <= {LW{1'b0}};
         r_lfsr <= {LW{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode <= mode;
                  r_err  <= 1'b0;
               end
            end
            S_CFG_PRE:  r_p    <= w_p_clamp;
            S_CFG_TAPS: r_taps <= data_out[LW-1:0];
            S_CFG_SEED: begin
               r_lfsr <= w_seed;
               r_idx  <= {CW{1'b0}};
               if (w_cfg_bad) r_err <= 1'b1;
            end
            S_PRE: begin
               r_lfsr <= w_lfsr_next;
               r_idx  <= w_pre_last ? {CW{1'b0}} : r_idx + C_ONE;
            end
            S_MSG: begin
               r_lfsr <= w_lfsr_next;
               r_idx  <= r_idx + C_ONE;
            end
            default: begin
               r_idx <= r_idx;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_cipher_engine.sv
// Self-checking bench for lfsr_cipher_engine: table-driven configs, abort and
// back-to-back corner sequences, and randomized runs against a keystream model.
module tb_lfsr_cipher_engine;

   logic       clk;
   logic       init;
   logic       start;
   logic       mode;
   logic [7:0] raddr;
   logic [7:0] data_out;
   logic       write_en;
   logic [7:0] waddr;
   logic [7:0] data_in;
   logic       busy;
   logic       done;
   logic       err;

   logic [7:0] mem [0:255];
   logic       tb_we;
   logic [7:0] tb_wa;
   logic [7:0] tb_wd;

   int total = 0;
   int bad = 0;

   int g_cyc[$], g_addr[$], g_data[$];
   int e_cyc[$], e_addr[$], e_data[$];
   int g_done, exp_done;
   logic g_err, g_err1, g_busy_ok, g_done_after, g_busy_after, g_err_after, exp_err;

   typedef struct {
      int   pre;
      int   taps;
      int   seed;
      int   exp_done;
      logic exp_err;
      int   exp_nw;
   } vec_t;
   vec_t vecs[10];

   lfsr_cipher_engine dut (
      .clk(clk), .init(init), .start(start), .mode(mode),
      .raddr(raddr), .data_out(data_out), .write_en(write_en),
      .waddr(waddr), .data_in(data_in), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign data_out = mem[raddr];

   always @(posedge clk) begin
      if (tb_we)         mem[tb_wa] <= tb_wd;
      else if (write_en) mem[waddr] <= data_in;
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic poke(input int a, input int v);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = a[7:0]; tb_wd = v[7:0];
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic set_cfg(input int pre, input int taps, input int seed);
      poke(61, pre); poke(62, taps); poke(63, seed);
   endtask

   // Keystream model: plain arithmetic over a private copy of memory.
   task automatic model(input logic m, input int pre_raw, input int tp, input int sd);
      int p, t, k, a, d;
      logic [7:0] mm [0:255];
      e_cyc.delete(); e_addr.delete(); e_data.delete();
      for (int i = 0; i < 256; i++) mm[i] = mem[i];
      p = (pre_raw > 15) ? 15 : pre_raw;
      t = tp % 64;
      k = sd % 64;
      if (t == 0 || k == 0) begin
         exp_done = 4; exp_err = 1'b1;
         return;
      end
      exp_done = 4 + p + 50; exp_err = 1'b0;
      for (int n = 0; n < p + 50; n++) begin
         a = -1; d = 0;
         if (n < p) begin
            if (!m) begin a = 64 + n; d = 95 ^ k; end
         end else if (!m) begin
            a = (64 + n) % 256; d = mm[n - p] ^ k;
         end else begin
            a = 128 + n - p; d = mm[(64 + n) % 256] ^ k;
         end
         if (a >= 0) begin
            e_cyc.push_back(4 + n); e_addr.push_back(a); e_data.push_back(d);
            mm[a] = d[7:0];
         end
         k = ((k * 2) % 64) + ($countones(k & t) % 2);
      end
   endtask

   task automatic run_op(input logic m, input logic hold);
      g_cyc.delete(); g_addr.delete(); g_data.delete();
      g_done = -1; g_err = 1'b0; g_err1 = 1'b0; g_busy_ok = 1'b1;
      @(negedge clk);
      start = 1'b1; mode = m;
      if (busy) g_busy_ok = 1'b0;
      @(negedge clk);
      if (!hold) start = 1'b0;
      for (int c = 1; c < 300 && g_done < 0; c++) begin
         if (c == 1) g_err1 = err;
         if (write_en) begin
            g_cyc.push_back(c); g_addr.push_back(int'(waddr)); g_data.push_back(int'(data_in));
         end
         if (done) begin g_done = c; g_err = err; end
         if (busy != !done) g_busy_ok = 1'b0;
         @(negedge clk);
      end
      g_done_after = done; g_busy_after = busy; g_err_after = err;
   endtask

   task automatic cmp_writes(input string name);
      check({name, "_nwr"}, g_addr.size(), e_addr.size());
      if (g_addr.size() == e_addr.size()) begin
         total++;
         for (int i = 0; i < g_addr.size(); i++) begin
            if (g_addr[i] != e_addr[i] || g_data[i] != e_data[i] || g_cyc[i] != e_cyc[i]) begin
               bad++;
               $display("FAIL %s_wr[%0d]: got cyc=%0d addr=%0d data=%0h expected cyc=%0d addr=%0d data=%0h",
                        name, i, g_cyc[i], g_addr[i], g_data[i], e_cyc[i], e_addr[i], e_data[i]);
               break;
            end
         end
      end
   endtask

   task automatic load_msg();
      string s;
      s = "Mr. Watson, come here. I want to see you.";
      for (int j = 0; j < 50; j++) poke(j, (j < s.len()) ? int'(s[j]) : 46);
   endtask

   initial begin
      int nbad, c, pre, tp, sd;
      start = 1'b0; mode = 1'b0; tb_we = 1'b0; tb_wa = 8'h00; tb_wd = 8'h00;
      init = 1'b0;
      #1 init = 1'b1;
      @(negedge clk);
      check("rst_outputs", int'({write_en, raddr, waddr, data_in, busy, done, err}), 0);
      for (int i = 0; i < 256; i++) poke(i, 0);
      check("rst_outputs_held", int'({write_en, raddr, waddr, data_in, busy, done, err}), 0);
      @(negedge clk);
      init = 1'b0;

      // Encrypt the reference message, then decrypt it back.
      load_msg();
      set_cfg(7, 8'h21, 8'h01);
      model(1'b0, 7, 8'h21, 8'h01);
      run_op(1'b0, 1'b0);
      cmp_writes("enc1");
      check("enc1_done_cyc", g_done, 61);
      check("enc1_busy", int'(g_busy_ok), 1);
      check("enc1_done_pulse", int'(g_done_after), 0);

      model(1'b1, 7, 8'h21, 8'h01);
      run_op(1'b1, 1'b0);
      cmp_writes("dec1");
      check("dec1_done_cyc", g_done, 61);
      nbad = 0;
      for (int j = 0; j < 50; j++) if (mem[128 + j] != mem[j]) nbad++;
      check("dec1_recover", nbad, 0);

      vecs[0] = '{7,   8'h21, 8'h01, 61, 1'b0, 57};
      vecs[1] = '{0,   8'h21, 8'h01, 54, 1'b0, 50};
      vecs[2] = '{200, 8'h21, 8'h01, 69, 1'b0, 65};
      vecs[3] = '{7,   8'h00, 8'h01, 4,  1'b1, 0};
      vecs[4] = '{16,  8'h21, 8'h01, 69, 1'b0, 65};
      vecs[5] = '{7,   8'h21, 8'h00, 4,  1'b1, 0};
      vecs[6] = '{15,  8'h3F, 8'h2A, 69, 1'b0, 65};
      vecs[7] = '{3,   8'hC0, 8'h01, 4,  1'b1, 0};
      vecs[8] = '{3,   8'h21, 8'h80, 4,  1'b1, 0};
      vecs[9] = '{1,   8'h30, 8'h3F, 55, 1'b0, 51};
      for (int v = 0; v < 10; v++) begin
         set_cfg(vecs[v].pre, vecs[v].taps, vecs[v].seed);
         model(1'b0, vecs[v].pre, vecs[v].taps, vecs[v].seed);
         run_op(1'b0, 1'b0);
         check($sformatf("vec%0d_done_cyc", v), g_done, vecs[v].exp_done);
         check($sformatf("vec%0d_err", v), int'(g_err), int'(vecs[v].exp_err));
         check($sformatf("vec%0d_nwr", v), g_addr.size(), vecs[v].exp_nw);
         check($sformatf("vec%0d_err_cleared", v), int'(g_err1), 0);
         check($sformatf("vec%0d_busy", v), int'(g_busy_ok), 1);
         if (vecs[v].exp_err) check($sformatf("vec%0d_err_held", v), int'(g_err_after), 1);
         if (vecs[v].pre == 0) begin
            check("pre0_first_cyc", g_cyc[0], 4);
            check("pre0_first_addr", g_addr[0], 64);
         end
         cmp_writes($sformatf("vec%0d", v));
      end

      // Abort with init in the middle of the message phase.
      for (int a = 64; a < 128; a++) poke(a, 8'hAA);
      set_cfg(7, 8'h21, 8'h01);
      model(1'b0, 7, 8'h21, 8'h01);
      @(negedge clk); start = 1'b1; mode = 1'b0;
      @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_at_j10", int'({write_en, waddr}), int'({1'b1, 8'd81}));
      #2 init = 1'b1;
      #1 check("abort_outputs", int'({write_en, raddr, waddr, data_in, busy, done, err}), 0);
      @(negedge clk);
      check("abort_no_write", int'(write_en), 0);
      check("abort_j10_untouched", int'(mem[81]), 8'hAA);
      check("abort_j9_written", int'(mem[80]), e_data[16]);
      init = 1'b0;
      @(negedge clk);
      run_op(1'b0, 1'b0);
      cmp_writes("rerun");
      check("rerun_done_cyc", g_done, 61);

      // start held high through a run: only the IDLE cycle after DONE restarts.
      run_op(1'b0, 1'b1);
      check("hold_done_cyc", g_done, 61);
      check("hold_idle_gap", int'({g_busy_after, g_done_after}), 0);
      @(negedge clk);
      start = 1'b0;
      check("hold_second_busy", int'(busy), 1);
      c = 1;
      while (!done && c < 300) begin @(negedge clk); c++; end
      check("hold_second_done_cyc", c, 61);

      // Randomized configurations and messages.
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 50; j++) poke(j, $urandom_range(0, 255));
         pre = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
         tp = $urandom_range(0, 255);
         sd = $urandom_range(0, 255);
         set_cfg(pre, tp, sd);
         for (int m = 0; m < 2; m++) begin
            model(m[0], pre, tp, sd);
            run_op(m[0], 1'b0);
            check($sformatf("rnd%0d_m%0d_done_cyc", r, m), g_done, exp_done);
            check($sformatf("rnd%0d_m%0d_err", r, m), int'(g_err), int'(exp_err));
            cmp_writes($sformatf("rnd%0d_m%0d", r, m));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
